// File: rtl/prio_pkg.sv
// Shared constants, stage states and elaboration helpers for the priority encoder.
package prio_pkg;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  // Bits needed to index n entries; never less than 1 so N=1 style corner cases keep a port.
  function automatic int unsigned clog2_safe(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

  // True when n is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational highest-set-bit finder: index of the top requesting line plus an any flag.
module prio_find
  import prio_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned W = clog2_safe(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Ascending scan; the last set bit seen is the highest one.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (vec_i[i]) begin
        idx_o = W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with EI/GS/EO cascade outputs, a one-deep
// valid/ready output stage and an optional descending round-robin grant.
module prio_encoder_rr
  import prio_pkg::*;
#(
  parameter  int unsigned N  = 16,
  parameter  int unsigned RR = PRIO_FIXED,
  localparam int unsigned W  = clog2_safe(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ei,
  input  logic [N-1:0] req,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] code,
  output logic         gs,
  output logic         eo,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam bit N_OK = is_pow2(N) && (N >= 2) && (N <= 256);

  generate
    if (!N_OK) begin : g_bad_n
      $error("prio_encoder_rr: N must be a power of two in 2..256");
    end
  endgenerate

  stage_state_e state_q;
  logic [W-1:0] code_q;
  logic         gs_q;
  logic         eo_q;
  logic [W-1:0] grant_idx;
  logic         any_req;
  logic         accept;

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = ~rst & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign code      = code_q;
  assign gs        = gs_q;
  assign eo        = eo_q;

  generate
    if (RR == PRIO_RR) begin : g_rr
      logic [W-1:0] ptr_q;
      logic [N-1:0] mask;
      logic [N-1:0] masked;
      logic [W-1:0] m_idx;
      logic         m_any;
      logic [W-1:0] u_idx;

      // Lines strictly below the last grant are preferred, giving a descending rotation.
      always_comb begin
        mask = '0;
        for (int i = 0; i < int'(N); i++) begin
          mask[i] = (i < int'(ptr_q));
        end
      end

      assign masked = req & mask;

      prio_find #(.N(N), .W(W)) u_find_masked (
        .vec_i (masked),
        .idx_o (m_idx),
        .any_o (m_any)
      );

      prio_find #(.N(N), .W(W)) u_find_full (
        .vec_i (req),
        .idx_o (u_idx),
        .any_o (any_req)
      );

      assign grant_idx = m_any ? m_idx : u_idx;

      // Pointer remembers the last index actually granted on a transfer.
      always_ff @(posedge clk) begin
        if (rst) begin
          ptr_q <= '0;
        end else if (accept && ei && any_req) begin
          ptr_q <= grant_idx;
        end
      end
    end else begin : g_fixed
      prio_find #(.N(N), .W(W)) u_find_full (
        .vec_i (req),
        .idx_o (grant_idx),
        .any_o (any_req)
      );
    end
  endgenerate

  // Output stage: load on accept, drain on consume, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      code_q  <= '0;
      gs_q    <= 1'b0;
      eo_q    <= 1'b0;
    end else if (accept) begin
      state_q <= ST_FULL;
      gs_q    <= ei & any_req;
      eo_q    <= ei & ~any_req;
      code_q  <= (ei & any_req) ? grant_idx : '0;
    end else if (out_ready && state_q == ST_FULL) begin
      state_q <= ST_EMPTY;
    end
  end

endmodule
